// File: rtl/morra_pkg.sv
// rtl/morra_pkg.sv - shared round/match codes, FSM states and match constants for the morra stages
package morra_pkg;

  typedef enum logic [1:0] {
    NON_VALIDA    = 2'b00,
    VINCE_SECONDO = 2'b01,
    VINCE_PRIMO   = 2'b10,
    PAREGGIO      = 2'b11
  } manche_t;

  typedef enum logic [1:0] {
    IN_CORSO        = 2'b00,
    PARTITA_SECONDO = 2'b01,
    PARTITA_PRIMO   = 2'b10,
    PARTITA_PARI    = 2'b11
  } partita_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GIOCO = 2'b01,
    FINE  = 2'b10
  } stato_t;

  localparam int BASE_MANCHE = 4;
  localparam int MIN_MANCHE  = 4;
  localparam int VANTAGGIO   = 2;

endpackage

// File: rtl/morra_verdetto.sv
// rtl/morra_verdetto.sv - combinational end-of-match decision on the post-update scores and count
module morra_verdetto #(
  parameter int CW         = 5,
  parameter int MIN_MANCHE = 4,
  parameter int VANTAGGIO  = 2
) (
  input  logic [CW-1:0] primo,
  input  logic [CW-1:0] secondo,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] max_manche,
  output logic          termina,
  output logic [1:0]    esito
);
  import morra_pkg::*;

  logic signed [CW:0] diff;
  logic        [CW:0] distacco;
  logic               per_vantaggio;
  logic               per_limite;

  assign diff     = $signed({1'b0, primo}) - $signed({1'b0, secondo});
  assign distacco = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);

  assign per_vantaggio = (count >= CW'(MIN_MANCHE)) && (distacco >= (CW+1)'(VANTAGGIO));
  assign per_limite    = (count == max_manche);
  assign termina       = per_vantaggio || per_limite;

  always_comb begin
    esito = IN_CORSO;
    if (termina) begin
      if (primo > secondo)      esito = PARTITA_PRIMO;
      else if (secondo > primo) esito = PARTITA_SECONDO;
      else                      esito = PARTITA_PARI;
    end
  end

endmodule

// File: rtl/morra_punteggio.sv
// rtl/morra_punteggio.sv - match scorekeeper; MORRA_STATISTICHE_EN adds draw/invalid round counters
module morra_punteggio #(
  parameter int BASE_MANCHE = morra_pkg::BASE_MANCHE,
  parameter int MIN_MANCHE  = morra_pkg::MIN_MANCHE,
  parameter int VANTAGGIO   = morra_pkg::VANTAGGIO,
  parameter int CW          = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inizio,
  input  logic [3:0]    limite,
  input  logic          manche_valid,
  input  logic [1:0]    manche,
  output logic [1:0]    partita,
  output logic          fine,
  output logic [CW-1:0] punti_primo,
  output logic [CW-1:0] punti_secondo,
  output logic [CW-1:0] count_manche,
  output logic [CW-1:0] max_manche
`ifdef MORRA_STATISTICHE_EN
  ,
  output logic [CW-1:0] pareggi,
  output logic [CW-1:0] invalide
`endif
);
  import morra_pkg::*;

  stato_t        stato, stato_n;
  logic [1:0]    partita_n;
  logic [CW-1:0] primo_n, secondo_n, count_n, max_n;
  logic [CW-1:0] primo_u, secondo_u, count_u;
  logic          accetta, termina;
  logic [1:0]    esito;

  assign accetta = (stato == GIOCO) && manche_valid && !inizio;
  assign fine    = (stato == FINE);

  // Tentative post-round values, fed to the verdict before being committed.
  always_comb begin
    primo_u   = punti_primo;
    secondo_u = punti_secondo;
    count_u   = count_manche;
    if (accetta) begin
      case (manche_t'(manche))
        VINCE_PRIMO: begin
          primo_u = punti_primo + CW'(1);
          count_u = count_manche + CW'(1);
        end
        VINCE_SECONDO: begin
          secondo_u = punti_secondo + CW'(1);
          count_u   = count_manche + CW'(1);
        end
        PAREGGIO: count_u = count_manche + CW'(1);
        default:  ;
      endcase
    end
  end

  morra_verdetto #(
    .CW         (CW),
    .MIN_MANCHE (MIN_MANCHE),
    .VANTAGGIO  (VANTAGGIO)
  ) u_verdetto (
    .primo      (primo_u),
    .secondo    (secondo_u),
    .count      (count_u),
    .max_manche (max_manche),
    .termina    (termina),
    .esito      (esito)
  );

  always_comb begin
    stato_n   = stato;
    partita_n = partita;
    primo_n   = punti_primo;
    secondo_n = punti_secondo;
    count_n   = count_manche;
    max_n     = max_manche;
    if (inizio) begin
      stato_n   = GIOCO;
      partita_n = IN_CORSO;
      primo_n   = '0;
      secondo_n = '0;
      count_n   = '0;
      max_n     = CW'(BASE_MANCHE) + CW'(limite);
    end else if (accetta) begin
      primo_n   = primo_u;
      secondo_n = secondo_u;
      count_n   = count_u;
      if (termina) begin
        stato_n   = FINE;
        partita_n = esito;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stato         <= IDLE;
      partita       <= '0;
      punti_primo   <= '0;
      punti_secondo <= '0;
      count_manche  <= '0;
      max_manche    <= '0;
    end else begin
      stato         <= stato_n;
      partita       <= partita_n;
      punti_primo   <= primo_n;
      punti_secondo <= secondo_n;
      count_manche  <= count_n;
      max_manche    <= max_n;
    end
  end

`ifdef MORRA_STATISTICHE_EN
  always_ff @(posedge clk) begin
    if (!rst_n || inizio) begin
      pareggi  <= '0;
      invalide <= '0;
    end else if (accetta) begin
      if (manche_t'(manche) == PAREGGIO)
        pareggi <= pareggi + CW'(1);
      if (manche_t'(manche) == NON_VALIDA && invalide != '1)
        invalide <= invalide + CW'(1);
    end
  end
`endif

endmodule

// File: doc/morra_punteggio.md
Name: morra_punteggio

Overview:
- Downstream stage of the rock-paper-scissors round evaluator.
- Consumes one 2-bit round result ("manche") per accepted handshake.
- Keeps per-player scores and the round count, and decides when the match ("partita") ends and who won.
- Holds the final match verdict until the next match start.

Parameters:
BASE_MANCHE, 4, base of the maximum round count; the start value is added to it.
MIN_MANCHE, 4, number of valid rounds that must be played before a lead can end the match.
VANTAGGIO, 2, score lead that ends the match early.
CW, 5, width of the counters and scores; must hold BASE_MANCHE+15.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
inizio  in  1  match start; loads the limit and clears all counters.
limite  in  4  extra rounds, i.e. {primo,secondo} sampled when inizio=1.
manche_valid  in  1  round result present this cycle.
manche  in  2  round code: 00 invalid, 01 player 2 wins, 10 player 1 wins, 11 draw.
partita  out  2  match code: 00 in progress or idle, 01 player 2 won, 10 player 1 won, 11 draw.
fine  out  1  high while the state is FINE.
punti_primo  out  CW  player 1 score.
punti_secondo  out  CW  player 2 score.
count_manche  out  CW  valid rounds played.
max_manche  out  CW  loaded round limit.

Behaviour:
- Reset: when rst_n=0 at a rising edge, state=IDLE and every output/register is 0. Reset has priority over all other inputs, including mid-match.
- States:
  - IDLE: inizio -> GIOCO.
  - GIOCO: an accepted round that meets the end condition -> FINE.
  - FINE: inizio -> GIOCO.
  - inizio=1 in any state at a clock edge: max_manche <= BASE_MANCHE + zero-extended limite; scores, count and partita cleared; next state GIOCO.
- Priority: inizio beats manche_valid in the same cycle; that round is discarded.
- Accept rule: a round is accepted only when state=GIOCO, manche_valid=1 and inizio=0. manche_valid is ignored in IDLE and FINE; there is no backpressure.
- Code 00: accepted but has no effect. Count and scores are unchanged.
- Code 01/10/11: count_manche +1. The winner's score +1 (01 -> secondo, 10 -> primo). Draw (11): no score change.
- End check uses the post-update values:
  - Lead end: count >= MIN_MANCHE and |primo - secondo| >= VANTAGGIO -> leader wins.
  - Limit end: otherwise, if count == max_manche -> higher score wins; equal scores -> 11.
  - The difference is computed signed at CW+1 bits; no wrap is possible because scores never exceed max_manche.
- Latency: partita, fine and the counters update at the same edge that accepts the round, and are visible the following cycle.
- partita stays 00 in GIOCO and holds its verdict in FINE until inizio or reset.
- Count saturation: once count reaches max_manche the state leaves GIOCO, so the count never exceeds the limit.

Optional Feature:
- Macro: MORRA_STATISTICHE_EN.
- Defined: adds outputs pareggi (CW) and invalide (CW).
  - pareggi counts accepted code-11 rounds.
  - invalide counts accepted code-00 rounds and saturates at all-ones.
  - Both clear on reset and on inizio.
- Not defined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package morra_pkg holds:
  - typedef manche_t: 2-bit enum NON_VALIDA=00, VINCE_SECONDO=01, VINCE_PRIMO=10, PAREGGIO=11.
  - typedef partita_t: same encoding with IN_CORSO=00.
  - typedef stato_t: IDLE, GIOCO, FINE.
  - The constants BASE_MANCHE, MIN_MANCHE, VANTAGGIO.
- Shared with the round evaluator.
- One natural sub-module: morra_verdetto, a combinational end-condition and winner decision taking the next-state scores, count and max.

Test Plan:
- Reset check: rst_n=0 for 2 cycles mid-match at count=3 -> all outputs 0 and state IDLE; manche_valid afterwards is ignored until inizio.
- Early lead: inizio with limite=0011 (max=7), then rounds 10,10,01,10 -> after the 4th round primo=3, secondo=1, partita=10, fine=1; a further round 01 leaves the scores unchanged.
- No early end before MIN_MANCHE: limite=0000, rounds 10,10,10 -> partita=00 after 3 rounds; the 4th round 10 -> partita=10.
- Draw at limit: limite=0000 (max=4), rounds 10,01,11,11 -> count=4, scores 1-1, partita=11.
- Invalid rounds do not count: rounds 00,00,10 -> count=1, primo=1; with MORRA_STATISTICHE_EN, invalide=2.
- Simultaneous events: inizio=1 with manche_valid=1 and manche=10 during FINE -> counters 0, partita=00, state GIOCO, round discarded.
